wb_regfile: RTL and testbench

Write-back stage and architectural register file for the 19-bit pipelined CPU. It consumes the MEM/WB pipeline register outputs and selects the write-back value: load data or ALU result. It commits that value to one of eight 19-bit registers and serves two combinational read ports to decode, with same-cycle write-through bypass. It also keeps a retired-write counter and a last-write capture for debug.

---
 rtl/wb_regfile.sv | 104 ++++++++++
 tb/tb_wb_regfile.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back mux plus an 8 x 19-bit architectural register file. It has two
// combinational read ports with same-cycle bypass and keeps debug commit tracking.

module wb_regfile_rdport #(
  parameter bit R0_ZERO = 1'b0
) (
  input  logic [2:0]       addr_i,
  input  logic             commit_i,
  input  logic [2:0]       wb_rd_i,
  input  logic [18:0]      wb_data_i,
  input  logic [7:0][18:0] regs_i,
  output logic [18:0]      data_o
);
  always_comb begin
    data_o = regs_i[addr_i];
    if (R0_ZERO && addr_i == 3'd0)
      data_o = '0;
    else if (commit_i && wb_rd_i == addr_i)
      data_o = wb_data_i;
  end
endmodule

module wb_regfile #(
  parameter bit R0_ZERO = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             WB_regwrite,
  input  logic             WB_memtoreg,
  input  logic [18:0]      WB_rdata,
  input  logic [18:0]      WB_out,
  input  logic [2:0]       WB_rd,
  input  logic [2:0]       rs1_addr,
  input  logic [2:0]       rs2_addr,
  output logic [18:0]      rs1_data,
  output logic [18:0]      rs2_data,
  output logic [18:0]      wb_data,
  output logic [2:0]       last_rd,
  output logic [18:0]      last_wdata,
  output logic             last_valid,
  output logic [CNT_W-1:0] wr_count,
  input  logic             clr_count
);
  localparam int NUM_RD = 2;

  logic [7:0][18:0]        regs_q;
  logic [2:0]              last_rd_q;
  logic [18:0]             last_wdata_q;
  logic                    last_valid_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    commit;
  logic [NUM_RD-1:0][2:0]  rd_addr;
  logic [NUM_RD-1:0][18:0] rd_data;

  assign wb_data = WB_memtoreg ? WB_rdata : WB_out;
  assign commit  = WB_regwrite && !(R0_ZERO && WB_rd == 3'd0);

  // Clear takes precedence over a same-edge commit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count)   cnt_d = '0;
    else if (commit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= '0;
      last_rd_q    <= '0;
      last_wdata_q <= '0;
      last_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (commit) begin
        regs_q[WB_rd] <= wb_data;
        last_rd_q     <= WB_rd;
        last_wdata_q  <= wb_data;
        last_valid_q  <= 1'b1;
      end
    end
  end

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_regfile_rdport #(.R0_ZERO(R0_ZERO)) u_port (
      .addr_i    (rd_addr[p]),
      .commit_i  (commit),
      .wb_rd_i   (WB_rd),
      .wb_data_i (wb_data),
      .regs_i    (regs_q),
      .data_o    (rd_data[p])
    );
  end

  assign rs1_data   = rd_data[0];
  assign rs2_data   = rd_data[1];
  assign last_rd    = last_rd_q;
  assign last_wdata = last_wdata_q;
  assign last_valid = last_valid_q;
  assign wr_count   = cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one instance with R0 hardwired to zero and one without,
// both driven from shared inputs and both using a 4-bit counter so that wrap is reachable.

module tb_wb_regfile;
  logic clk = 1'b0, rst_n = 1'b0;
  logic we = 1'b0, m2r = 1'b0, clr = 1'b0;
  logic [18:0] rdata = '0, wout = '0;
  logic [2:0] rd = '0, a1 = '0, a2 = '0;
  logic [18:0] r1, r2, wbd, lwd, r1z, r2z, wbdz, lwdz;
  logic [2:0] lrd, lrdz;
  logic lv, lvz;
  logic [3:0] cnt, cntz;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.R0_ZERO(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .WB_regwrite(we), .WB_memtoreg(m2r),
    .WB_rdata(rdata), .WB_out(wout), .WB_rd(rd),
    .rs1_addr(a1), .rs2_addr(a2), .rs1_data(r1), .rs2_data(r2),
    .wb_data(wbd), .last_rd(lrd), .last_wdata(lwd), .last_valid(lv),
    .wr_count(cnt), .clr_count(clr));

  wb_regfile #(.R0_ZERO(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .WB_regwrite(we), .WB_memtoreg(m2r),
    .WB_rdata(rdata), .WB_out(wout), .WB_rd(rd),
    .rs1_addr(a1), .rs2_addr(a2), .rs1_data(r1z), .rs2_data(r2z),
    .wb_data(wbdz), .last_rd(lrdz), .last_wdata(lwdz), .last_valid(lvz),
    .wr_count(cntz), .clr_count(clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic w, input logic m, input logic c, input logic [18:0] rdat,
                     input logic [18:0] o, input logic [2:0] d, input logic [2:0] x1,
                     input logic [2:0] x2);
    we = w; m2r = m; clr = c; rdata = rdat; wout = o; rd = d; a1 = x1; a2 = x2;
  endtask

  typedef struct {
    logic we, m2r, clr;
    logic [18:0] rdata, out;
    logic [2:0] rd, a1, a2;
    logic [18:0] e_wb, e_r1, e_r2, e_r1z, e_lwd;
    logic [2:0] e_lrd;
    logic e_lv;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Expected values describe what is seen in the cycle the vector is presented.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 19'h2A5A5, 19'h00011, 3'd3, 3'd3, 3'd0,
               19'h2A5A5, 19'h2A5A5, 19'h0, 19'h2A5A5, 19'h0, 3'd0, 1'b0, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 3'd3, 3'd3,
               19'h0, 19'h2A5A5, 19'h2A5A5, 19'h2A5A5, 19'h2A5A5, 3'd3, 1'b1, 4'd1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 19'h2A5A5, 19'h00011, 3'd3, 3'd3, 3'd1,
               19'h00011, 19'h00011, 19'h0, 19'h00011, 19'h2A5A5, 3'd3, 1'b1, 4'd1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 3'd3, 3'd2,
               19'h0, 19'h00011, 19'h0, 19'h00011, 19'h00011, 3'd3, 1'b1, 4'd2};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 19'h0, 19'h7FFFF, 3'd5, 3'd5, 3'd5,
               19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h00011, 3'd3, 1'b1, 4'd2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 3'd5, 3'd5,
               19'h0, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 3'd5, 1'b1, 4'd3};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 19'h0, 19'h12345, 3'd0, 3'd0, 3'd0,
               19'h12345, 19'h0, 19'h0, 19'h12345, 19'h7FFFF, 3'd5, 1'b1, 4'd3};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 3'd0, 3'd5,
               19'h0, 19'h0, 19'h7FFFF, 19'h12345, 19'h7FFFF, 3'd5, 1'b1, 4'd3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 19'h0, 19'h55555, 3'd2, 3'd2, 3'd2,
               19'h55555, 19'h0, 19'h0, 19'h0, 19'h7FFFF, 3'd5, 1'b1, 4'd3};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 19'h0, 19'h0, 3'd0, 3'd2, 3'd3,
               19'h0, 19'h0, 19'h00011, 19'h0, 19'h7FFFF, 3'd5, 1'b1, 4'd3};

    // Reset state
    #2;
    chk("rst_rs1", r1, 0); chk("rst_cnt", cnt, 0); chk("rst_lv", lv, 0);
    chk("rst_lrd", lrd, 0); chk("rst_lwd", lwd, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drv(tbl[i].we, tbl[i].m2r, tbl[i].clr, tbl[i].rdata, tbl[i].out,
          tbl[i].rd, tbl[i].a1, tbl[i].a2);
      #1;
      chk($sformatf("v%0d_wb", i), wbd, tbl[i].e_wb);
      chk($sformatf("v%0d_rs1", i), r1, tbl[i].e_r1);
      chk($sformatf("v%0d_rs2", i), r2, tbl[i].e_r2);
      chk($sformatf("v%0d_rs1_nozero", i), r1z, tbl[i].e_r1z);
      chk($sformatf("v%0d_lwd", i), lwd, tbl[i].e_lwd);
      chk($sformatf("v%0d_lrd", i), lrd, tbl[i].e_lrd);
      chk($sformatf("v%0d_lv", i), lv, tbl[i].e_lv);
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].e_cnt);
    end

    // Counter clear alone, then 17 commits wrap a 4-bit counter to 1
    @(negedge clk); drv(1'b0, 1'b0, 1'b1, '0, '0, 3'd0, 3'd0, 3'd0);
    @(negedge clk); drv(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, 3'd0, 3'd0);
    #1 chk("clr_cnt", cnt, 0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); drv(1'b1, 1'b0, 1'b0, '0, 19'(i + 1), 3'd1, 3'd0, 3'd0);
    end
    @(negedge clk); drv(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, 3'd1, 3'd1);
    #1;
    chk("wrap_cnt", cnt, 1); chk("wrap_lrd", lrd, 1);
    chk("wrap_lwd", lwd, 17); chk("wrap_r1", r1, 17);

    // Clear together with a commit: register updates, counter goes to 0
    @(negedge clk); drv(1'b1, 1'b0, 1'b1, '0, 19'h0ABCD, 3'd6, 3'd0, 3'd0);
    @(negedge clk); drv(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, 3'd6, 3'd0);
    #1;
    chk("clrw_cnt", cnt, 0); chk("clrw_r6", r1, 19'h0ABCD); chk("clrw_lrd", lrd, 6);

    // Asynchronous reset mid-cycle with nonzero state
    @(negedge clk); drv(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, 3'd3, 3'd6);
    #1 chk("pre_rst_r3", r1, 19'h00011);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rs1", r1, 0); chk("arst_rs2", r2, 0); chk("arst_cnt", cnt, 0);
    chk("arst_lv", lv, 0); chk("arst_lwd", lwd, 0);
    // Bypass follows the live inputs during reset; the edge's write is lost
    drv(1'b1, 1'b0, 1'b0, '0, 19'h01111, 3'd4, 3'd4, 3'd0);
    #1 chk("rst_bypass", r1, 19'h01111);
    @(negedge clk); rst_n = 1'b1; drv(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, 3'd4, 3'd0);
    #1;
    chk("lost_r4", r1, 0); chk("lost_cnt", cnt, 0); chk("lost_lv", lv, 0);
    @(negedge clk); drv(1'b1, 1'b1, 1'b0, 19'h02222, 19'h0, 3'd4, 3'd0, 3'd0);
    @(negedge clk); drv(1'b0, 1'b0, 1'b0, '0, '0, 3'd0, 3'd4, 3'd0);
    #1;
    chk("post_r4", r1, 19'h02222); chk("post_cnt", cnt, 1); chk("post_lv", lv, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
